// File: rtl/nonce_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nonce_decoder_pkg: state encoding and hit-vector helper functions      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package nonce_decoder_pkg;

  localparam int MAX_CORES = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    SEARCH = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  function automatic logic [5:0] lowest_set(input logic [MAX_CORES-1:0] vec);
    logic [5:0] idx;
    idx = '0;
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      if (vec[i]) idx = 6'(i);
    end
    return idx;
  endfunction

  function automatic logic [6:0] popcount(input logic [MAX_CORES-1:0] vec);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_CORES; i++) begin
      cnt = cnt + 7'(vec[i]);
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nonce_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nonce_fifo: show-ahead synchronous FIFO with sync clear               |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module nonce_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i && !empty_o;
    // A pop frees the slot the push lands in, so full+pop still accepts.
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/nonce_decoder_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nonce_decoder_mc: collects per-core hits into full nonces and queues  |
// | them for the reporter; emits a no-solution record on exhaustion.      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module nonce_decoder_mc
  import nonce_decoder_pkg::*;
#(
  parameter int NUM_CORES     = 10,
  parameter int BROADCAST_CNT = 100,
  parameter int FIFO_DEPTH    = 4,
  parameter int NONCE_W       = 32,
  parameter int CORE_IDX_W    = $clog2(NUM_CORES),
  parameter int PREFIX_W      = NONCE_W - CORE_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 newblock_i,
  input  logic                 valid_i,
  input  logic [NUM_CORES-1:0] core_success_i,
  input  logic [PREFIX_W-1:0]  nonce_prefix_i,
  input  logic                 exhausted_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic                 success_o,
  output logic [NONCE_W-1:0]   nonce_o,
  output logic                 overflow_o,
  output logic [7:0]           dropped_o,
  output logic                 done_o
);

  localparam int CNT_W = (BROADCAST_CNT > 1) ? $clog2(BROADCAST_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (BROADCAST_CNT > 0) ? CNT_W'(BROADCAST_CNT - 1) : '0;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    hit_q, hit_d;
  logic                    overflow_q, overflow_d;
  logic [7:0]              dropped_q, dropped_d;

  logic [MAX_CORES-1:0]    hits_ext;
  logic [CORE_IDX_W-1:0]   core_idx;
  logic [6:0]              hit_count;
  logic [8:0]              drop_sum;
  logic                    hit_valid;
  logic                    nosol;
  logic                    fifo_full, fifo_empty, fifo_pop;
  logic [NONCE_W-1:0]      fifo_dout;

  always_comb begin
    hits_ext                 = '0;
    hits_ext[NUM_CORES-1:0]  = core_success_i;
    core_idx  = CORE_IDX_W'(lowest_set(hits_ext));
    hit_count = popcount(hits_ext);
    drop_sum  = 9'(dropped_q) + 9'(hit_count) - 9'd1;
    hit_valid = valid_i && (|core_success_i) && (state_q == SEARCH) && !newblock_i;
    fifo_pop  = !fifo_empty && ready_i;
    nosol     = (state_q == DRAIN) && fifo_empty && !hit_q;
  end

  nonce_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (newblock_i),
    .push_i  (hit_valid),
    .pop_i   (fifo_pop),
    .din_i   ({nonce_prefix_i, core_idx}),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hit_q      <= hit_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (newblock_i) begin
      state_d = (BROADCAST_CNT == 0) ? SEARCH : FLUSH;
      cnt_d   = CNT_INIT;
    end else begin
      case (state_q)
        IDLE:    ;
        FLUSH: begin
          if (cnt_q == '0) state_d = SEARCH;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        SEARCH:  if (exhausted_i) state_d = DRAIN;
        // With a hit this block, an empty queue means everything went out.
        DRAIN:   if (fifo_empty && (hit_q || ready_i)) state_d = DONE;
        DONE:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hit_d      = hit_q;
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    if (newblock_i) begin
      hit_d      = 1'b0;
      overflow_d = 1'b0;
      dropped_d  = '0;
    end else if (hit_valid) begin
      hit_d = 1'b1;
      if (fifo_full && !fifo_pop) overflow_d = 1'b1;
      dropped_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end
  end

  always_comb begin
    valid_o    = !fifo_empty || nosol;
    success_o  = !fifo_empty;
    nonce_o    = fifo_empty ? '0 : fifo_dout;
    done_o     = (state_q == DONE);
    overflow_o = overflow_q;
    dropped_o  = dropped_q;
  end

endmodule
`default_nettype wire
